// File: rtl/rob_pkg.sv
// Shared types for the multi-ID read reorder buffer: slot state, response code
// and per-slot bookkeeping record.
package rob_pkg;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        PENDING = 2'd1,
        FILLED  = 2'd2
    } slot_state_e;

    typedef logic [1:0] resp_t;

    typedef struct packed {
        slot_state_e state;
        resp_t       resp;
    } slot_meta_t;

endpackage

// File: rtl/rob_slot_array.sv
// Slot storage for the reorder buffer: per-slot state/ID/data/resp, the ID CAM
// used by the AR and R paths, and the head-slot read port.
module rob_slot_array
    import rob_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_en,
    input  logic [$clog2(DEPTH)-1:0]   alloc_idx,
    input  logic [ID_WIDTH-1:0]        alloc_id,
    input  logic                       fill_en,
    input  logic [$clog2(DEPTH)-1:0]   fill_idx,
    input  logic [DATA_WIDTH-1:0]      fill_data,
    input  logic [1:0]                 fill_resp,
    input  logic                       free_en,
    input  logic [$clog2(DEPTH)-1:0]   free_idx,
    input  logic [ID_WIDTH-1:0]        ar_id,
    output logic                       ar_hit,
    input  logic [ID_WIDTH-1:0]        r_id,
    output logic                       pend_hit,
    output logic [$clog2(DEPTH)-1:0]   pend_idx,
    input  logic [$clog2(DEPTH)-1:0]   head_idx,
    output slot_state_e                head_state,
    output logic [ID_WIDTH-1:0]        head_id,
    output logic [DATA_WIDTH-1:0]      head_data,
    output logic [1:0]                 head_resp
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    slot_meta_t            meta_q [DEPTH];
    slot_meta_t            meta_d [DEPTH];
    logic [ID_WIDTH-1:0]   id_q   [DEPTH];
    logic [ID_WIDTH-1:0]   id_d   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];

    // Slot updates; allocate, fill and free always target distinct slots.
    always_comb begin
        meta_d = meta_q;
        id_d   = id_q;
        data_d = data_q;
        if (alloc_en) begin
            meta_d[alloc_idx].state = PENDING;
            id_d[alloc_idx]         = alloc_id;
        end
        if (fill_en) begin
            meta_d[fill_idx].state = FILLED;
            meta_d[fill_idx].resp  = fill_resp;
            data_d[fill_idx]       = fill_data;
        end
        if (free_en) begin
            meta_d[free_idx].state = FREE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                meta_q[i] <= '{state: FREE, resp: 2'b00};
            end
        end else begin
            meta_q <= meta_d;
        end
    end

    always_ff @(posedge clk) begin
        id_q   <= id_d;
        data_q <= data_d;
    end

    // CAM: IDs are unique among live slots, so at most one entry matches.
    always_comb begin
        ar_hit   = 1'b0;
        pend_hit = 1'b0;
        pend_idx = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (meta_q[i].state != FREE && id_q[i] == ar_id) begin
                ar_hit = 1'b1;
            end
            if (meta_q[i].state == PENDING && id_q[i] == r_id) begin
                pend_hit = 1'b1;
                pend_idx = IDX_W'(i);
            end
        end
    end

    assign head_state = meta_q[head_idx].state;
    assign head_id    = id_q[head_idx];
    assign head_data  = data_q[head_idx];
    assign head_resp  = meta_q[head_idx].resp;

endmodule

// File: rtl/reorder_buffer_multi.sv
// AXI read reorder buffer: returns R responses in AR-acceptance order.
// Define ROB_BYPASS_EN to forward a head-slot response straight to the slave.
module reorder_buffer_multi
    import rob_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ID_WIDTH-1:0]      s_arid_i,
    input  logic                     s_arvalid_i,
    output logic                     s_arready_o,
    output logic [ID_WIDTH-1:0]      m_arid_o,
    output logic                     m_arvalid_o,
    input  logic                     m_arready_i,
    output logic [DATA_WIDTH-1:0]    s_rdata_o,
    output logic [ID_WIDTH-1:0]      s_rid_o,
    output logic [1:0]               s_rresp_o,
    output logic                     s_rvalid_o,
    input  logic                     s_rready_i,
    input  logic [DATA_WIDTH-1:0]    m_rdata_i,
    input  logic [ID_WIDTH-1:0]      m_rid_i,
    input  logic [1:0]               m_rresp_i,
    input  logic                     m_rvalid_i,
    output logic                     m_rready_o,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic                     unexpected_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = IDX_W + 1;

    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             unexpected_q, unexpected_d;

    logic                  ar_hit, pend_hit, ar_ok, ar_hs, r_hs, drain, bypass;
    logic [IDX_W-1:0]      pend_idx;
    slot_state_e           head_state;
    logic [ID_WIDTH-1:0]   head_id;
    logic [DATA_WIDTH-1:0] head_data;
    logic [1:0]            head_resp;

    // AR passes through; blocked when full or when the ID is still live.
    assign ar_ok       = ~rst & (occ_q < OCC_W'(DEPTH)) & ~ar_hit;
    assign m_arid_o    = s_arid_i;
    assign m_arvalid_o = s_arvalid_i & ar_ok;
    assign s_arready_o = m_arready_i & ar_ok;
    assign ar_hs       = s_arvalid_i & m_arready_i & ar_ok;

    assign m_rready_o  = ~rst;
    assign r_hs        = m_rvalid_i & m_rready_o;

`ifdef ROB_BYPASS_EN
    assign bypass = ~rst & (head_state == PENDING) & m_rvalid_i
                  & (m_rid_i == head_id) & s_rready_i;
`else
    assign bypass = 1'b0;
`endif

    assign s_rvalid_o = (~rst & (head_state == FILLED)) | bypass;
    assign s_rdata_o  = bypass ? m_rdata_i : head_data;
    assign s_rid_o    = bypass ? m_rid_i   : head_id;
    assign s_rresp_o  = bypass ? m_rresp_i : head_resp;
    assign drain      = s_rvalid_o & s_rready_i;

    assign occupancy_o  = occ_q;
    assign unexpected_o = unexpected_q;

    always_comb begin
        head_d       = head_q + IDX_W'(drain);
        tail_d       = tail_q + IDX_W'(ar_hs);
        occ_d        = occ_q + OCC_W'(ar_hs) - OCC_W'(drain);
        unexpected_d = r_hs & ~pend_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            occ_q        <= '0;
            unexpected_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            occ_q        <= occ_d;
            unexpected_q <= unexpected_d;
        end
    end

    rob_slot_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH),
        .DEPTH      (DEPTH)
    ) u_slots (
        .clk        (clk),
        .rst        (rst),
        .alloc_en   (ar_hs),
        .alloc_idx  (tail_q),
        .alloc_id   (s_arid_i),
        .fill_en    (r_hs & pend_hit & ~bypass),
        .fill_idx   (pend_idx),
        .fill_data  (m_rdata_i),
        .fill_resp  (m_rresp_i),
        .free_en    (drain),
        .free_idx   (head_q),
        .ar_id      (s_arid_i),
        .ar_hit     (ar_hit),
        .r_id       (m_rid_i),
        .pend_hit   (pend_hit),
        .pend_idx   (pend_idx),
        .head_idx   (head_q),
        .head_state (head_state),
        .head_id    (head_id),
        .head_data  (head_data),
        .head_resp  (head_resp)
    );

endmodule

// File: tb/tb_reorder_buffer_multi.sv
// Bench for reorder_buffer_multi (default parameters, ROB_BYPASS_EN undefined):
// queue-based reference model checked every cycle plus directed literal checks.
module tb_reorder_buffer_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] s_arid_i;
    logic       s_arvalid_i;
    logic       s_arready_o;
    logic [3:0] m_arid_o;
    logic       m_arvalid_o;
    logic       m_arready_i;
    logic [7:0] s_rdata_o;
    logic [3:0] s_rid_o;
    logic [1:0] s_rresp_o;
    logic       s_rvalid_o;
    logic       s_rready_i;
    logic [7:0] m_rdata_i;
    logic [3:0] m_rid_i;
    logic [1:0] m_rresp_i;
    logic       m_rvalid_i;
    logic       m_rready_o;
    logic [4:0] occupancy_o;
    logic       unexpected_o;

    int n_chk  = 0;
    int n_fail = 0;
    bit armed  = 1'b0;

    reorder_buffer_multi dut (
        .clk          (clk),
        .rst          (rst),
        .s_arid_i     (s_arid_i),
        .s_arvalid_i  (s_arvalid_i),
        .s_arready_o  (s_arready_o),
        .m_arid_o     (m_arid_o),
        .m_arvalid_o  (m_arvalid_o),
        .m_arready_i  (m_arready_i),
        .s_rdata_o    (s_rdata_o),
        .s_rid_o      (s_rid_o),
        .s_rresp_o    (s_rresp_o),
        .s_rvalid_o   (s_rvalid_o),
        .s_rready_i   (s_rready_i),
        .m_rdata_i    (m_rdata_i),
        .m_rid_i      (m_rid_i),
        .m_rresp_i    (m_rresp_i),
        .m_rvalid_i   (m_rvalid_i),
        .m_rready_o   (m_rready_o),
        .occupancy_o  (occupancy_o),
        .unexpected_o (unexpected_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: outstanding IDs in acceptance order, per-ID response store.
    int         q[$];
    bit         m_filled [16];
    logic [7:0] m_data   [16];
    logic [1:0] m_resp   [16];
    bit         m_unexp;

    function automatic bit in_q(input logic [3:0] id);
        foreach (q[i]) if (q[i] == int'(id)) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        bit pend, drain, accept;
        if (rst) begin
            q.delete();
            for (int i = 0; i < 16; i++) m_filled[i] = 1'b0;
            m_unexp = 1'b0;
        end else begin
            pend   = in_q(m_rid_i) && !m_filled[m_rid_i];
            drain  = q.size() > 0 && m_filled[q[0]] && s_rready_i;
            accept = s_arvalid_i && m_arready_i && q.size() < 16 && !in_q(s_arid_i);
            m_unexp = m_rvalid_i && !pend;
            if (m_rvalid_i && pend) begin
                m_filled[m_rid_i] = 1'b1;
                m_data[m_rid_i]   = m_rdata_i;
                m_resp[m_rid_i]   = m_rresp_i;
            end
            if (drain) begin
                m_filled[q[0]] = 1'b0;
                void'(q.pop_front());
            end
            if (accept) q.push_back(int'(s_arid_i));
        end
    end

    always @(negedge clk) begin
        bit ev, ok;
        int hid;
        if (armed) begin
            ev = !rst && q.size() > 0 && m_filled[q[0]];
            ok = !rst && q.size() < 16 && !in_q(s_arid_i);
            chk("occupancy", 32'(occupancy_o), 32'(q.size()));
            chk("s_rvalid", 32'(s_rvalid_o), 32'(ev));
            if (ev) begin
                hid = q[0];
                chk("s_rid", 32'(s_rid_o), 32'(hid));
                chk("s_rdata", 32'(s_rdata_o), 32'(m_data[hid]));
                chk("s_rresp", 32'(s_rresp_o), 32'(m_resp[hid]));
            end
            chk("unexpected", 32'(unexpected_o), 32'(m_unexp));
            chk("s_arready", 32'(s_arready_o), 32'(ok && m_arready_i));
            chk("m_arvalid", 32'(m_arvalid_o), 32'(ok && s_arvalid_i));
            chk("m_arid", 32'(m_arid_o), 32'(s_arid_i));
            chk("m_rready", 32'(m_rready_o), 32'(!rst));
        end
    end

    // Slave-side delivery log for ordering checks.
    logic [3:0] log_id[$];
    logic [7:0] log_data[$];
    always @(negedge clk) begin
        if (armed && !rst && s_rvalid_o && s_rready_i) begin
            log_id.push_back(s_rid_o);
            log_data.push_back(s_rdata_o);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_ar(input logic [3:0] id);
        s_arvalid_i = 1'b1;
        s_arid_i    = id;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (s_arready_o) begin
                @(posedge clk); #1;
                s_arvalid_i = 1'b0;
                return;
            end
        end
        chk("ar_timeout", 32'(0), 32'(1));
        s_arvalid_i = 1'b0;
    endtask

    task automatic send_r(input logic [3:0] id, input logic [7:0] d, input logic [1:0] r);
        m_rvalid_i = 1'b1;
        m_rid_i    = id;
        m_rdata_i  = d;
        m_rresp_i  = r;
        @(posedge clk); #1;
        m_rvalid_i = 1'b0;
    endtask

    task automatic wait_empty();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (occupancy_o == 5'd0) begin
                @(posedge clk); #1;
                return;
            end
        end
        chk("drain_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        logic [3:0] ord[16];
        rst = 1'b1; s_arid_i = '0; s_arvalid_i = 1'b0; m_arready_i = 1'b1;
        s_rready_i = 1'b0; m_rdata_i = '0; m_rid_i = '0; m_rresp_i = '0; m_rvalid_i = 1'b0;
        cyc(2);
        armed = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_occ", 32'(occupancy_o), 32'(0));
        chk("rst_rvalid", 32'(s_rvalid_o), 32'(0));
        chk("rst_unexp", 32'(unexpected_o), 32'(0));
        chk("rst_arready", 32'(s_arready_o), 32'(0));
        chk("rst_rready", 32'(m_rready_o), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // 16 ARs 0..15, responses 15..0, delivered 0..15
        s_rready_i = 1'b1;
        log_id.delete(); log_data.delete();
        for (int i = 0; i < 16; i++) send_ar(4'(i));
        for (int i = 15; i >= 0; i--) send_r(4'(i), 8'(8'hA0 + i), 2'(i));
        wait_empty();
        chk("order_cnt", 32'(log_id.size()), 32'(16));
        for (int i = 0; i < 16 && i < log_id.size(); i++) begin
            chk("order_id", 32'(log_id[i]), 32'(i));
            chk("order_data", 32'(log_data[i]), 32'(8'hA0 + i));
        end

        // Full buffer: 17th AR (ID 3) waits for the first drain
        s_rready_i = 1'b0;
        ord = '{4'd3, 4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7,
                4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
        for (int i = 0; i < 16; i++) send_ar(ord[i]);
        for (int i = 15; i >= 0; i--) send_r(4'(i), 8'(8'h30 + i), 2'b00);
        s_arvalid_i = 1'b1; s_arid_i = 4'd3;
        cyc(3);
        @(negedge clk);
        chk("full_arready", 32'(s_arready_o), 32'(0));
        chk("full_occ", 32'(occupancy_o), 32'(16));
        @(posedge clk); #1; s_rready_i = 1'b1;
        @(negedge clk);
        chk("full_drain_arready", 32'(s_arready_o), 32'(0));
        chk("full_head_rid", 32'(s_rid_o), 32'(3));
        @(posedge clk); #1; s_rready_i = 1'b0;
        @(negedge clk);
        chk("after_drain_arready", 32'(s_arready_o), 32'(1));
        chk("after_drain_occ", 32'(occupancy_o), 32'(15));
        @(posedge clk); #1; s_arvalid_i = 1'b0;
        send_r(4'd3, 8'hC3, 2'b11);
        s_rready_i = 1'b1;
        wait_empty();

        // Duplicate ID 5 stalls until the first ID 5 is delivered
        s_rready_i = 1'b0;
        send_ar(4'd5);
        s_arvalid_i = 1'b1; s_arid_i = 4'd5;
        cyc(3);
        @(negedge clk);
        chk("dup_stall", 32'(s_arready_o), 32'(0));
        @(posedge clk); #1;
        send_r(4'd5, 8'h55, 2'b01);
        cyc(2);
        s_rready_i = 1'b1;
        @(negedge clk);
        chk("dup_drain_cycle", 32'(s_arready_o), 32'(0));
        @(posedge clk); #1; s_rready_i = 1'b0;
        @(negedge clk);
        chk("dup_release", 32'(s_arready_o), 32'(1));
        @(posedge clk); #1; s_arvalid_i = 1'b0;
        send_r(4'd5, 8'h56, 2'b10);
        s_rready_i = 1'b1;
        wait_empty();

        // Unknown ID 9 with ID 1 outstanding, then unknown ID 2 while empty
        s_rready_i = 1'b0;
        send_ar(4'd1);
        send_r(4'd9, 8'h99, 2'b00);
        @(negedge clk);
        chk("unexp_pulse", 32'(unexpected_o), 32'(1));
        chk("unexp_occ", 32'(occupancy_o), 32'(1));
        @(posedge clk); #1;
        @(negedge clk);
        chk("unexp_clear", 32'(unexpected_o), 32'(0));
        @(posedge clk); #1;
        send_r(4'd1, 8'h11, 2'b00);
        s_rready_i = 1'b1;
        wait_empty();
        send_r(4'd2, 8'h22, 2'b00);
        @(negedge clk);
        chk("unexp_empty", 32'(unexpected_o), 32'(1));
        chk("unexp_empty_occ", 32'(occupancy_o), 32'(0));
        @(posedge clk); #1;

        // Backpressure: head held for 10 cycles
        s_rready_i = 1'b0;
        send_ar(4'd7);
        send_r(4'd7, 8'h5A, 2'b10);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_rvalid", 32'(s_rvalid_o), 32'(1));
            chk("hold_rdata", 32'(s_rdata_o), 32'(8'h5A));
            chk("hold_rid", 32'(s_rid_o), 32'(7));
            @(posedge clk); #1;
        end
        s_rready_i = 1'b1;
        wait_empty();

        // Reset with 6 outstanding, then reuse IDs
        s_rready_i = 1'b0;
        for (int i = 10; i < 16; i++) send_ar(4'(i));
        send_r(4'd12, 8'hEC, 2'b00);
        send_r(4'd10, 8'hEA, 2'b00);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst6_occ", 32'(occupancy_o), 32'(0));
        chk("rst6_rvalid", 32'(s_rvalid_o), 32'(0));
        @(posedge clk); #1;
        log_id.delete(); log_data.delete();
        send_ar(4'd10);
        send_ar(4'd11);
        send_r(4'd11, 8'hB1, 2'b00);
        send_r(4'd10, 8'hB0, 2'b00);
        s_rready_i = 1'b1;
        wait_empty();
        chk("reuse_cnt", 32'(log_id.size()), 32'(2));
        if (log_id.size() == 2) begin
            chk("reuse_id0", 32'(log_id[0]), 32'(10));
            chk("reuse_data0", 32'(log_data[0]), 32'(8'hB0));
            chk("reuse_id1", 32'(log_id[1]), 32'(11));
            chk("reuse_data1", 32'(log_data[1]), 32'(8'hB1));
        end

        cyc(2);
        armed = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
